sequence_generator: RTL
=======================

# sequence_generator

Serial pattern transmitter that drives the single-bit `w` input of the lab's FSM sequence detectors. It takes a parallel pattern of up to `WIDTH` bits, shifts it out MSB-first one bit per `step` strobe, and optionally loops. It reports progress through `busy`, a one-cycle `done` pulse and a bit counter. It sits beside the detector on the board, or in the bench, as its stimulus source.

## Interface
- `WIDTH`, 16: maximum pattern length in bits.
- `LEN_W`, 5: width of `length` and `bit_count`; must hold `WIDTH`.

Ports:
- `clock` in 1: system clock; all logic is on the rising edge.
- `resetn` in 1: reset, synchronous, active-low.
- `start` in 1: request a transmission; sampled only in IDLE.
- `pattern` in WIDTH: bits to send; bit `length-1` is sent first and bit 0 last.
- `length` in LEN_W: number of bits to send; valid range is 1..WIDTH.
- `loop` in 1: when 1, the sequence restarts after its last bit; sampled on every last-bit step.
- `step` in 1: advance-one-bit strobe; may be held high to advance every cycle.
- `abort` in 1: cancel an active transmission.
- `w` out 1: registered serial output.
- `busy` out 1: 1 while in SEND.
- `done` out 1: one-cycle pulse after a non-looped sequence completes.
- `bit_count` out LEN_W: index of the bit currently on `w`, 0-based.
- `state` out 2: current state, for LED display.

## Operation
- States: IDLE=2'b00, SEND=2'b01, DONE=2'b10. Code 2'b11 is illegal and recovers to IDLE on the next edge with all outputs 0.
- Internal registers:
  - shift register `sreg[WIDTH-1:0]`; `w = sreg[WIDTH-1]`.
  - saved copy of the pattern and length, used for looping.
- IDLE:
  - Outputs: `w=0`, `busy=0`, `done=0`, `bit_count=0`.
  - `start=1` with `1 <= length <= WIDTH`: load `sreg = pattern << (WIDTH-length)`, save pattern and length, go to SEND.
  - `start=1` with `length==0` or `length>WIDTH`: ignored; stay in IDLE, no `done`.
  - `step` and `abort` are ignored.
- SEND:
  - Outputs: `busy=1`; `w` shows the current bit.
  - `abort=1`: go to IDLE next edge. Outputs clear; no `done`. `abort` has priority over `step`.
  - `step=1` and `bit_count < length-1`: shift `sreg` left by 1 and increment `bit_count`.
  - `step=1` and `bit_count == length-1`, with `loop=1`: reload `sreg` from the saved pattern, set `bit_count=0`, stay in SEND.
  - `step=1` and `bit_count == length-1`, with `loop=0`: go to DONE.
  - `start` and changes on `pattern`/`length` are ignored; the saved copies are used.
- DONE: exactly one cycle with `done=1`, `busy=0`, `w=0`, `bit_count=0`, then IDLE unconditionally. A `start` in DONE is ignored.
- Reset: state IDLE, `sreg=0`, `bit_count=0`, `w=busy=done=0`. Reset overrides everything, including mid-SEND.

## Timing
- `start` is sampled at edge t. At t+1: `busy=1`, first bit on `w`, `bit_count=0`.
- Each bit is held until the first edge at which `step=1`. With `step` tied high, one bit is sent per cycle.
- A `step` in the same cycle as `start` is not counted. The first bit is always held at least one cycle.
- A step sampled on the last bit at edge e:
  - `loop=0`: `done=1` during e+1 to e+2, then IDLE; a new `start` is accepted at e+2.
  - `loop=1`: the first bit reappears at e+1 with no gap cycle.
- Latency is `length` cycles from `start` to `done` with `step` held high, plus 1 cycle for DONE.
- `length==1`: a single bit; the next step ends the sequence, or reloads it if `loop=1`.

## Test plan
- `pattern=16'h000D`, `length=4`, `step`=1 continuously, `start` pulse at t:
  - `w` = 1,1,0,1 at t+1..t+4, `bit_count` 0..3.
  - `busy` high t+1..t+4.
  - `done` high at t+5 only; `state` returns to 00 at t+6.
- Same pattern with `step` pulsed every 3rd cycle: each bit is held exactly 3 cycles, and `done` comes 1 cycle after the 4th step.
- `pattern=16'h0006`, `length=3`, `loop=1`, `step`=1:
  - `w` = 1,1,0,1,1,0,… with no gap and `done` never asserted.
  - `abort` at cycle 7: IDLE next edge, `w=0`, `busy=0`, no `done`.
- `start` with `length=0`, then with `length=17`: `state` stays 00 and all outputs stay 0.
- `pattern=16'hA5C3`, `length=16`, `step`=1:
  - `w` = 1010 0101 1100 0011, MSB-first.
  - A `start` pulse with a different pattern at bit 5 is ignored.
  - `resetn=0` at bit 9: all outputs 0 and `state=00` at the next edge.

Source files
------------

// File: rtl/sequence_generator_if.sv
// Pin bundle between a pattern source/controller and the serial sequence generator.
// master drives the request side; slave is the generator itself.
interface sequence_generator_if #(
    parameter int WIDTH = 16,
    parameter int LEN_W = 5
);
    logic             start;
    logic [WIDTH-1:0] pattern;
    logic [LEN_W-1:0] length;
    logic             loop;
    logic             step;
    logic             abort;
    logic             w;
    logic             busy;
    logic             done;
    logic [LEN_W-1:0] bit_count;
    logic [1:0]       state;

    modport master (
        output start, pattern, length, loop, step, abort,
        input  w, busy, done, bit_count, state
    );

    modport slave (
        input  start, pattern, length, loop, step, abort,
        output w, busy, done, bit_count, state
    );
endinterface

// File: rtl/sequence_generator.sv
// Serial pattern transmitter: shifts a parallel pattern out MSB-first on w,
// one bit per step strobe, with optional looping and a one-cycle done pulse.
module sequence_generator #(
    parameter int WIDTH = 16,
    parameter int LEN_W = 5
) (
    input  logic                 clock,
    input  logic                 resetn,
    sequence_generator_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SEND = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;

    logic             len_ok;
    logic             last_bit;
    logic [WIDTH-1:0] aligned;

    assign len_ok   = (bus.length != '0) && (bus.length <= LEN_W'(WIDTH));
    assign last_bit = (cnt_q == (len_q - LEN_W'(1)));
    // The saved copy is stored already left-aligned so a loop reload is a plain copy.
    assign aligned  = bus.pattern << (LEN_W'(WIDTH) - bus.length);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            pat_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        pat_d   = pat_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                sreg_d = '0;
                cnt_d  = '0;
                if (bus.start && len_ok) begin
                    sreg_d  = aligned;
                    pat_d   = aligned;
                    len_d   = bus.length;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (bus.abort) begin
                    state_d = IDLE;
                    sreg_d  = '0;
                    cnt_d   = '0;
                end else if (bus.step) begin
                    if (!last_bit) begin
                        sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
                        cnt_d  = cnt_q + LEN_W'(1);
                    end else if (bus.loop) begin
                        sreg_d = pat_q;
                        cnt_d  = '0;
                    end else begin
                        state_d = DONE;
                        sreg_d  = '0;
                        cnt_d   = '0;
                    end
                end
            end
            // DONE and the unused 2'b11 code both fall back to IDLE with outputs cleared.
            default: begin
                state_d = IDLE;
                sreg_d  = '0;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.w         = sreg_q[WIDTH-1];
    assign bus.busy      = (state_q == SEND);
    assign bus.done      = (state_q == DONE);
    assign bus.bit_count = cnt_q;
    assign bus.state     = state_q;
endmodule
